dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request acceptance to completion (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 2048, number of 32-bit words in the backing byte array (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port mem_req  input  1  core requests an access this cycle.
REQ-006 SHALL have port mem_write_en  input  1  1 = write, 0 = read; sampled with mem_req.
REQ-007 SHALL have port mem_addr  input  32  byte address from core.
REQ-008 SHALL have port mem_data_in  input  4x8 (byte array [0:3])  write data; byte i goes to address base+i.
REQ-009 SHALL have port mem_data_out  output  4x8 (byte array [0:3])  read data; byte i from address base+i.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  request in flight; core stalls its PC while high.
REQ-012 SHALL have port addr_err  output  1  completed access was out of range; valid with mem_ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE: mem_req=1 SHALL latch mem_addr, mem_write_en and mem_data_in, load counter with LATENCY-1 and go to WAIT; if LATENCY=1, go directly to DONE.
REQ-015 WAIT: counter SHALL decrement each cycle; at counter=1, go to DONE.
REQ-016 Transition into DONE SHALL perform the array access: write stores 4 latched bytes, read captures 4 bytes into mem_data_out.
REQ-017 DONE: mem_ready=1 for exactly one cycle, then IDLE; total latency from accepting edge to mem_ready high = LATENCY cycles.
REQ-018 busy SHALL be 1 in WAIT and DONE, 0 in IDLE.
REQ-019 mem_req while busy=1 SHALL be ignored (no queueing); core re-issues after mem_ready.
REQ-020 mem_req sampled in DONE SHALL be ignored; a new request is accepted only in IDLE.
REQ-021 Word base = {mem_addr[31:2],2'b00}; mem_addr[1:0] SHALL be ignored (byte select is the core's job).
REQ-022 Address with word index >= DEPTH_WORDS SHALL set addr_err=1 with mem_ready, perform no write, and leave mem_data_out unchanged.
REQ-023 mem_data_out SHALL hold its last read value through writes and idle cycles until the next successful read.
REQ-024 A read of a word SHALL return the data of the most recent completed write to it (no stale data).
REQ-025 addr_err SHALL be 0 whenever mem_ready=0.

Reset
REQ-026 rst_b=0 at a clock edge SHALL force IDLE, counter=0, mem_ready=0, busy=0, addr_err=0, mem_data_out=all zero.
REQ-027 Reset during WAIT SHALL abort the access; the pending write SHALL NOT reach the array.
REQ-028 Array contents SHALL NOT be cleared by reset (testbench preloads via hierarchical access).

Structure
REQ-029 State enum (IDLE/WAIT/DONE) and default LATENCY/DEPTH_WORDS constants SHALL live in shared package mips_pkg.
REQ-030 Byte array SHALL be a sub-module dmem_array (4 byte lanes, synchronous write, one read port, no reset); FSM and counter stay in dmem_ctrl.

Verification
REQ-031 Write 0x11,0x22,0x33,0x44 to addr 0x100 then read 0x100, LATENCY=4 -> mem_ready 4 cycles after each accept; read returns [0x11,0x22,0x33,0x44], addr_err=0.
REQ-032 Read at addr 0x103 after REQ-031 -> same data as 0x100 (low bits ignored).
REQ-033 mem_req held high continuously -> accepts one request per LATENCY+1 cycles; requests during busy produce no extra mem_ready pulses.
REQ-034 Write to addr 0x2000 (word 2048, DEPTH_WORDS=2048) -> mem_ready with addr_err=1; subsequent read of 0x0000 unchanged; mem_data_out unchanged.
REQ-035 Write 0xAA.. to 0x40, assert rst_b=0 at cycle 2 of WAIT -> outputs zero next edge; read of 0x40 after reset returns preloaded value, not 0xAA.
REQ-036 LATENCY=1: read request -> mem_ready high on the cycle after the accepting edge, busy high for exactly that one cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// default timing/size constants and a small address helper.
package mips_pkg;

  // Access sequencing states of the data-memory controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Default access latency in cycles (legal range 1..15).
  localparam int unsigned DMEM_LATENCY_DEF = 4;

  // Default number of 32-bit words in the backing array.
  localparam int unsigned DMEM_DEPTH_DEF = 2048;

  // Width of the latency down-counter; holds values up to 15.
  localparam int unsigned DMEM_CNT_W = 4;

  // Word index of a byte address; the two byte-select bits are dropped.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised byte storage: four byte lanes sharing one word address,
// synchronous write and a combinational read port. Contents are never reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEF,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata [0:3],
  output logic [7:0]    rdata [0:3]
);

  // Byte i of each word lives in lane i.
  logic [7:0] mem [0:DEPTH_WORDS-1][0:3];

  // Store all four lanes of the addressed word when a write is committed.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        mem[addr][i] <= wdata[i];
      end
    end
  end

  // Read port follows the address directly; the controller registers it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = mem[addr][i];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one core request at a time, waits a fixed
// LATENCY, performs the array access on the edge entering DONE and returns a
// one-cycle mem_ready pulse with an out-of-range flag.
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LATENCY     = DMEM_LATENCY_DEF,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Control state (reset)
  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q,   cnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q,  busy_d;
  logic                  err_q,   err_d;
  logic [7:0]            dout_q [0:3];
  logic [7:0]            dout_d [0:3];

  // Latched request (not reset; only meaningful while a request is in flight)
  logic [29:0]           widx_q,  widx_d;
  logic                  we_q,    we_d;
  logic [7:0]            wdata_q [0:3];
  logic [7:0]            wdata_d [0:3];

  // Access actually presented to the array this cycle
  logic [29:0]           acc_widx;
  logic                  acc_we;
  logic [7:0]            acc_wdata [0:3];
  logic                  acc_in_range;
  logic                  go_done;
  logic                  arr_we;
  logic [7:0]            arr_rdata [0:3];

  // Byte-select bits are deliberately not used by the controller.
  logic                  addr_lsb_unused;
  assign addr_lsb_unused = ^mem_addr[1:0];

  // Select the access source: with LATENCY=1 the access happens on the very
  // edge that accepts the request, so the live inputs must be used directly.
  always_comb begin
    if (state_q == IDLE) begin
      acc_widx  = word_index(mem_addr);
      acc_we    = mem_write_en;
      acc_wdata = mem_data_in;
    end else begin
      acc_widx  = widx_q;
      acc_we    = we_q;
      acc_wdata = wdata_q;
    end
    acc_in_range = (acc_widx >> AW) == 30'd0;
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    go_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          widx_d  = word_index(mem_addr);
          we_d    = mem_write_en;
          wdata_d = mem_data_in;
          if (LATENCY == 1) begin
            state_d = DONE;
            go_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = DMEM_CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      DONE: begin
        // Requests seen here are dropped; the core re-issues from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The access itself is tied to the transition into DONE.
    if (go_done) begin
      ready_d = 1'b1;
      err_d   = ~acc_in_range;
      if (!acc_we && acc_in_range) begin
        dout_d = arr_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // A reset on the committing edge must keep the pending write out of the array.
  assign arr_we = go_done && acc_we && acc_in_range && rst_b;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (acc_widx[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // FSM, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Request capture registers; contents are don't-care outside an access.
  always_ff @(posedge clk) begin
    widx_q  <= widx_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  assign mem_ready    = ready_q;
  assign busy         = busy_q;
  assign addr_err     = err_q;
  assign mem_data_out = dout_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a word-level memory model.
module tb_dmem_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned NPRE  = 128;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_req;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_ready;
  logic        busy;
  logic        addr_err;

  logic        r1_req;
  logic        r1_we;
  logic [31:0] r1_addr;
  logic [7:0]  r1_din  [0:3];
  logic [7:0]  r1_dout [0:3];
  logic        r1_ready;
  logic        r1_busy;
  logic        r1_err;

  int checks   = 0;
  int failures = 0;

  // Model: word w holds byte0 in [31:24] ... byte3 in [7:0].
  logic [31:0] ref_mem [NPRE];
  logic [31:0] ref_dout;

  always #5 clk = ~clk;

  dmem_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .busy(busy), .addr_err(addr_err)
  );

  dmem_ctrl #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) dut1 (
    .clk(clk), .rst_b(rst_b), .mem_req(r1_req), .mem_write_en(r1_we),
    .mem_addr(r1_addr), .mem_data_in(r1_din), .mem_data_out(r1_dout),
    .mem_ready(r1_ready), .busy(r1_busy), .addr_err(r1_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dout_word();
    return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  endfunction

  task automatic set_din(input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem_data_in[b] = w[8*(3-b) +: 8];
  endtask

  // One complete transaction on the LATENCY=4 instance. While the request is
  // in flight (and in DONE) random requests are driven, which must be ignored.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic [29:0] widx;
    logic        inr;
    int          lat;
    widx = addr[31:2];
    inr  = (widx < DEPTH);
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = we; mem_addr = addr; set_din(data);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!mem_ready) check("busy_in_flight", {31'd0, busy}, 32'd1);
      mem_req = 1'(($urandom % 2)); mem_write_en = 1'b1;
      mem_addr = $urandom; set_din($urandom);
      if (mem_ready) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, LAT);
    check("addr_err", {31'd0, addr_err}, {31'd0, ~inr});
    check("busy_at_ready", {31'd0, busy}, 32'd1);
    if (inr) begin
      if (we) ref_mem[widx] = data;
      else    ref_dout = ref_mem[widx];
    end
    check("data_out", dout_word(), ref_dout);
    @(negedge clk);
    mem_req = 1'b0;
    check("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("err_without_ready", {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    int pulses;
    int pos [$];
    logic [31:0] a;

    rst_b = 1'b0; mem_req = 1'b0; mem_write_en = 1'b0; mem_addr = '0; set_din('0);
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0;
    for (int b = 0; b < 4; b++) r1_din[b] = 8'h00;
    ref_dout = '0;

    // Preload both arrays through hierarchy.
    for (int w = 0; w < NPRE; w++) begin
      ref_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) begin
        dut.u_array.mem[w][b]  <= ref_mem[w][8*(3-b) +: 8];
        dut1.u_array.mem[w][b] <= ref_mem[w][8*(3-b) +: 8];
      end
    end

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    check("rst_dout", dout_word(), 32'd0);
    check("rst_busy_l1", {31'd0, r1_busy}, 32'd0);
    rst_b = 1'b1;

    // Basic write then read, low address bits ignored.
    do_txn(1'b1, 32'h100, 32'h11223344);
    do_txn(1'b0, 32'h100, 32'h0);
    check("rd_0x100", dout_word(), 32'h11223344);
    do_txn(1'b0, 32'h103, 32'h0);
    check("rd_0x103", dout_word(), 32'h11223344);

    // Out-of-range write, then data_out unchanged and word 0 intact.
    do_txn(1'b1, 32'h2000, 32'hDEADBEEF);
    check("oor_dout_kept", dout_word(), 32'h11223344);
    do_txn(1'b0, 32'h0000, 32'h0);
    check("rd_word0", dout_word(), ref_mem[0]);

    // Request held high: one accept per LAT+1 cycles, no extra pulses.
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h8;
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        pos.push_back(i);
      end
    end
    mem_req = 1'b0;
    check("held_pulses", pulses, 3);
    if (pos.size() == 3) begin
      check("held_first", pos[0], LAT);
      check("held_gap0", pos[1] - pos[0], LAT + 1);
      check("held_gap1", pos[2] - pos[1], LAT + 1);
    end
    ref_dout = ref_mem[2];
    repeat (LAT + 2) @(negedge clk);
    check("held_data", dout_word(), ref_dout);

    // Reset in the second WAIT cycle aborts a write.
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h40; set_din(32'hAAAAAAAA);
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, mem_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", {31'd0, addr_err}, 32'd0);
    check("abort_dout", dout_word(), 32'd0);
    rst_b = 1'b1;
    ref_dout = '0;
    repeat (LAT + 1) @(negedge clk);
    check("post_abort_idle", {31'd0, mem_ready}, 32'd0);
    do_txn(1'b0, 32'h40, 32'h0);
    check("abort_no_write", dout_word(), ref_mem[16]);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 8 == 0) a = 32'h2000 + ($urandom % 32'h1000);
      else                   a = (($urandom % 64) << 2) | ($urandom % 4);
      do_txn(1'(($urandom % 2)), a, $urandom);
    end

    // LATENCY=1 instance: ready and busy on the cycle after acceptance only.
    @(negedge clk);
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h14;
    @(negedge clk);
    r1_req = 1'b0;
    check("l1_ready", {31'd0, r1_ready}, 32'd1);
    check("l1_busy", {31'd0, r1_busy}, 32'd1);
    check("l1_err", {31'd0, r1_err}, 32'd0);
    check("l1_data", {r1_dout[0], r1_dout[1], r1_dout[2], r1_dout[3]}, ref_mem[5]);
    @(negedge clk);
    check("l1_ready_off", {31'd0, r1_ready}, 32'd0);
    check("l1_busy_off", {31'd0, r1_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
